// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-period pulse with a double-buffered, clamped compare,
// period and prescale that are reloaded only at period boundaries.
module servo_pwm_gen #(
  parameter int unsigned CNTR_BITS = 16,
  parameter int unsigned CMP_MIN   = 0,
  parameter int unsigned CMP_MAX   = 2**CNTR_BITS - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNTR_BITS-1:0] cmp_in,
  input  logic [CNTR_BITS-1:0] period,
  input  logic [CNTR_BITS-1:0] prescale,
  output logic                 pwm_out,
  output logic                 period_start,
  output logic [CNTR_BITS-1:0] cmp_active
);

  localparam int unsigned EXT_BITS = CNTR_BITS + 1;
  localparam logic [CNTR_BITS-1:0] ONE   = CNTR_BITS'(1);
  localparam logic [CNTR_BITS-1:0] MIN_C = CNTR_BITS'(CMP_MIN);
  localparam logic [CNTR_BITS-1:0] MAX_C = CNTR_BITS'(CMP_MAX);
  localparam logic [EXT_BITS-1:0]  MIN_E = EXT_BITS'(CMP_MIN);
  localparam logic [EXT_BITS-1:0]  MAX_E = EXT_BITS'(CMP_MAX);

  logic                 running, running_d;
  logic [CNTR_BITS-1:0] pre_cnt, pre_d;
  logic [CNTR_BITS-1:0] per_cnt, per_d;
  logic [CNTR_BITS-1:0] period_act, period_d;
  logic [CNTR_BITS-1:0] prescale_act, prescale_d;
  logic [CNTR_BITS-1:0] cmp_d;
  logic                 pwm_d, start_d;
  logic                 tick, wrap, load;
  logic [EXT_BITS-1:0]  cmp_ext;
  logic [CNTR_BITS-1:0] cmp_clamped;

  // Clamp in one extra bit so neither bound collapses to a constant comparison.
  always_comb begin
    cmp_ext     = {1'b0, cmp_in};
    cmp_clamped = cmp_in;
    if ((cmp_ext + EXT_BITS'(1)) <= MIN_E) cmp_clamped = MIN_C;
    else if (cmp_ext > MAX_E)              cmp_clamped = MAX_C;
  end

  // Next-state: disable dominates, then load, then normal counting.
  always_comb begin
    running_d  = running;
    pre_d      = pre_cnt;
    per_d      = per_cnt;
    period_d   = period_act;
    prescale_d = prescale_act;
    cmp_d      = cmp_active;
    start_d    = 1'b0;
    tick       = running && (pre_cnt == prescale_act);
    wrap       = tick && (per_cnt == (period_act - ONE));
    load       = en && (!running || wrap);

    if (!en) begin
      running_d = 1'b0;
      pre_d     = '0;
      per_d     = '0;
    end else if (load) begin
      running_d  = 1'b1;
      pre_d      = '0;
      per_d      = '0;
      cmp_d      = cmp_clamped;
      period_d   = (period == '0) ? ONE : period;
      prescale_d = prescale;
      start_d    = 1'b1;
    end else if (running) begin
      if (tick) begin
        pre_d = '0;
        per_d = per_cnt + ONE;
      end else begin
        pre_d = pre_cnt + ONE;
      end
    end

    // Output is computed from next-state values so the flop matches per_cnt.
    pwm_d = running_d && (per_d < cmp_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running      <= 1'b0;
      pre_cnt      <= '0;
      per_cnt      <= '0;
      period_act   <= '0;
      prescale_act <= '0;
      cmp_active   <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      running      <= running_d;
      pre_cnt      <= pre_d;
      per_cnt      <= per_d;
      period_act   <= period_d;
      prescale_act <= prescale_d;
      cmp_active   <= cmp_d;
      pwm_out      <= pwm_d;
      period_start <= start_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen: one default instance and one with a narrow clamp range.
module tb_servo_pwm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] cmp_in, period, prescale;
  logic        pwm0, ps0, pwm1, ps1;
  logic [15:0] cmpa0, cmpa1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(.CNTR_BITS(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .cmp_in(cmp_in), .period(period),
    .prescale(prescale), .pwm_out(pwm0), .period_start(ps0), .cmp_active(cmpa0)
  );

  servo_pwm_gen #(.CNTR_BITS(16), .CMP_MIN(2), .CMP_MAX(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .cmp_in(cmp_in), .period(period),
    .prescale(prescale), .pwm_out(pwm1), .period_start(ps1), .cmp_active(cmpa1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check n cycles of waveform starting at clk-phase ph of a period of per cycles.
  task automatic run_wave(input string tag, input int sel, input int n, input int ph,
                          input int per, input int high);
    for (int i = 0; i < n; i++) begin
      int phase;
      phase = (ph + i) % per;
      check({tag, "_pwm"}, (sel == 1) ? pwm1 : pwm0, (phase < high) ? 1 : 0);
      check({tag, "_ps"},  (sel == 1) ? ps1  : ps0,  (phase == 0) ? 1 : 0);
      step();
    end
  endtask

  task automatic restart(input int p, input int pre, input int c);
    en = 1'b0;
    step();
    period   = 16'(p);
    prescale = 16'(pre);
    cmp_in   = 16'(c);
    en       = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cmp_in = '0; period = '0; prescale = '0;
    step(); step();
    check("rst_pwm", pwm0, 0);
    check("rst_ps", ps0, 0);
    check("rst_cmp", cmpa0, 0);
    rst_n = 1'b1;
    step();
    check("idle_pwm", pwm0, 0);

    // Basic waveform: 3 high / 7 low
    period = 16'd10; prescale = 16'd0; cmp_in = 16'd3; en = 1'b1;
    step();
    check("basic_cmp", cmpa0, 3);
    run_wave("basic", 0, 20, 0, 10, 3);

    // Deferred update: change requested width in cycle 5
    run_wave("defer_pre", 0, 5, 0, 10, 3);
    cmp_in = 16'd6;
    run_wave("defer_cur", 0, 4, 5, 10, 3);
    check("defer_cmp_old", cmpa0, 3);
    step();
    check("defer_cmp_new", cmpa0, 6);
    run_wave("defer_next", 0, 10, 0, 10, 6);

    // Prescale: period 20 cycles, high 8
    restart(10, 1, 4);
    check("pre_cmp", cmpa0, 4);
    run_wave("pre", 0, 40, 0, 20, 8);

    // Disable while high, then re-enable
    restart(10, 0, 3);
    step();
    check("dis_hi_pwm", pwm0, 1);
    en = 1'b0;
    step();
    check("dis_pwm", pwm0, 0);
    check("dis_ps", ps0, 0);
    check("dis_cmp_hold", cmpa0, 3);
    run_wave("dis_idle", 0, 12, 1, 1000, 0);
    en = 1'b1;
    step();
    run_wave("reen", 0, 19, 0, 10, 3);

    // Wrap coincident with disable: no load, no period_start
    en = 1'b0;
    step();
    check("wrapdis_ps", ps0, 0);
    check("wrapdis_pwm", pwm0, 0);

    // Full-on: cmp beyond period
    restart(4, 0, 7);
    check("full_cmp", cmpa0, 7);
    run_wave("full", 0, 12, 0, 4, 4);

    // Zero period treated as 1
    restart(0, 0, 1);
    run_wave("zero", 0, 6, 0, 1, 1);

    // Clamp on narrow-range instance
    restart(10, 0, 0);
    check("clamp_lo_cmp", cmpa1, 2);
    check("clamp_lo_cmp_wide", cmpa0, 0);
    run_wave("clamp_lo", 1, 10, 0, 10, 2);
    restart(10, 0, 15);
    check("clamp_hi_cmp", cmpa1, 8);
    check("clamp_hi_cmp_wide", cmpa0, 15);
    run_wave("clamp_hi", 1, 10, 0, 10, 8);

    // Asynchronous reset mid-high
    restart(10, 0, 3);
    step();
    check("rstmid_pre_pwm", pwm0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_pwm", pwm0, 0);
    check("rstmid_ps", ps0, 0);
    check("rstmid_cmp", cmpa0, 0);
    check("rstmid_pwm1", pwm1, 0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_pwm", pwm0, 0);
    check("post_rst_ps", ps0, 0);
    en = 1'b1;
    step();
    check("post_rst_start", ps0, 1);
    check("post_rst_pwm_on", pwm0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
